// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: DEPTH-entry circular buffer between two
// stages, with valid/ready on both sides and synchronous flush.
module pipe_stage_elastic #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [CW-1:0]    count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push;
    logic             pop;

    // Handshake flags come from the count register only, so neither
    // ready nor valid has a combinational path from the other side.
    assign in_ready_o  = (count_q != FULL);
    assign out_valid_o = (count_q != '0);
    assign count_o     = count_q;

    assign push = in_valid_i & in_ready_o & ~flush_i;
    assign pop  = out_valid_o & out_ready_i & ~flush_i;

    // Empty stage presents an all-zero bubble instead of stale data.
    assign out_data_o = out_valid_o ? mem[rd_ptr_q] : '0;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: directed vector table,
// hand sequences for streaming and async reset, then a random run.
module tb_pipe_stage_elastic;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    int passed = 0;
    int total  = 0;

    pipe_stage_elastic #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .count_o    (count)
    );

    always #5 clk = ~clk;

    // Upstream protocol: a stalled offer must be held until taken.
    property hold_p;
        @(posedge clk) disable iff (!rst)
        (in_valid && !in_ready && !flush) |=> (in_valid && $stable(in_data));
    endproperty
    assert property (hold_p) else $error("upstream dropped a stalled offer");

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        e_valid;
        logic        e_ready;
        logic [1:0]  e_count;
        logic [31:0] e_data;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic r,
                           input logic [1:0] c, input logic [31:0] d);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".ready"}, 64'(in_ready), 64'(r));
        chk({tag, ".count"}, 64'(count), 64'(c));
        chk({tag, ".data"}, 64'(out_data), 64'(d));
    endtask

    task automatic cyc(input logic iv, input logic [31:0] d,
                       input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[16];
    logic [31:0] q[$];

    initial begin
        // Inputs applied before an edge; expectations are state after it.
        vecs[0]  = '{1, 32'hDEADBEEF, 1, 0, 1, 1, 2'd1, 32'hDEADBEEF};
        vecs[1]  = '{0, 32'h0,        1, 0, 0, 1, 2'd0, 32'h0};
        vecs[2]  = '{1, 32'h11,       0, 0, 1, 1, 2'd1, 32'h11};
        vecs[3]  = '{1, 32'h22,       0, 0, 1, 0, 2'd2, 32'h11};
        vecs[4]  = '{1, 32'h33,       0, 0, 1, 0, 2'd2, 32'h11};
        vecs[5]  = '{1, 32'h33,       1, 0, 1, 1, 2'd1, 32'h22};
        vecs[6]  = '{1, 32'h33,       1, 0, 1, 1, 2'd1, 32'h33};
        vecs[7]  = '{0, 32'h0,        1, 0, 0, 1, 2'd0, 32'h0};
        vecs[8]  = '{1, 32'hAA,       0, 0, 1, 1, 2'd1, 32'hAA};
        vecs[9]  = '{1, 32'hBB,       0, 0, 1, 0, 2'd2, 32'hAA};
        vecs[10] = '{1, 32'hCC,       0, 1, 0, 1, 2'd0, 32'h0};
        vecs[11] = '{1, 32'hDD,       0, 0, 1, 1, 2'd1, 32'hDD};
        vecs[12] = '{0, 32'h0,        1, 0, 0, 1, 2'd0, 32'h0};
        vecs[13] = '{1, 32'hEE,       0, 1, 0, 1, 2'd0, 32'h0};
        vecs[14] = '{1, 32'hEF,       1, 1, 0, 1, 2'd0, 32'h0};
        vecs[15] = '{0, 32'h0,        1, 0, 0, 1, 2'd0, 32'h0};

        #2;
        chk_all("in_reset", 1'b0, 1'b1, 2'd0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        chk_all("idle", 1'b0, 1'b1, 2'd0, 32'h0);

        for (int i = 0; i < 16; i++) begin
            cyc(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
            chk_all($sformatf("vec%0d", i), vecs[i].e_valid,
                    vecs[i].e_ready, vecs[i].e_count, vecs[i].e_data);
        end

        // Streaming: one in, one out per cycle across pointer wraps.
        for (int i = 1; i <= 10; i++) begin
            cyc(1, 32'(i), 1, 0);
            chk_all($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 32'(i));
        end
        cyc(0, 0, 1, 0);
        chk_all("stream_drain", 1'b0, 1'b1, 2'd0, 32'h0);

        // Async reset between edges while full.
        cyc(1, 32'h71, 0, 0);
        cyc(1, 32'h72, 0, 0);
        in_valid = 1'b0;
        chk_all("pre_reset", 1'b1, 1'b0, 2'd2, 32'h71);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_reset", 1'b0, 1'b1, 2'd0, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 32'h5A, 0, 0);
        chk_all("post_reset", 1'b1, 1'b1, 2'd1, 32'h5A);
        cyc(0, 0, 1, 0);
        chk_all("post_reset_pop", 1'b0, 1'b1, 2'd0, 32'h0);

        // Random traffic against a queue model of the stage.
        q.delete();
        begin
            logic        iv;
            logic [31:0] d;
            logic        ordy;
            logic        fl;
            logic        m_ready;
            logic        m_valid;
            logic        stalled;
            stalled = 1'b0;
            iv = 1'b0;
            d = '0;
            for (int n = 0; n < 400; n++) begin
                m_ready = (q.size() != DEPTH);
                m_valid = (q.size() != 0);
                chk("rnd.valid", 64'(out_valid), 64'(m_valid));
                chk("rnd.ready", 64'(in_ready), 64'(m_ready));
                chk("rnd.count", 64'(count), 64'(q.size()));
                chk("rnd.data", 64'(out_data), m_valid ? 64'(q[0]) : 64'h0);
                if (!stalled) begin
                    iv = ($urandom_range(0, 3) != 0);
                    d  = $urandom;
                end
                ordy = ($urandom_range(0, 2) != 0);
                fl   = ($urandom_range(0, 19) == 0);
                if (fl) begin
                    q.delete();
                end else begin
                    if (m_valid && ordy) void'(q.pop_front());
                    if (iv && m_ready) q.push_back(d);
                end
                stalled = iv && !m_ready && !fl;
                cyc(iv, d, ordy, fl);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed IF/ID/EX/MEM pipeline registers in the single-issue CPU.
- Replaces the free-running capture with a valid/ready handshake, DEPTH-entry elastic storage, and synchronous flush.
- Lets any stage stall its upstream without a global enable.
- Sits between two pipeline stages; WIDTH carries the packed stage payload (pc, inst, control, operands).

Parameters:
- WIDTH, 32: payload width in bits (≥1).
- DEPTH, 2: storage entries; power of two, ≥2. DEPTH=2 gives full-throughput skid behaviour.
- CW, $clog2(DEPTH+1): width of the occupancy count (derived; not to be overridden).

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush; discards all held and incoming data.
- in_valid_i  in  1  upstream has a payload.
- in_ready_o  out  1  stage can accept a payload this cycle.
- in_data_i  in  WIDTH  upstream payload.
- out_valid_o  out  1  head payload is valid.
- out_ready_i  in  1  downstream accepts the head.
- out_data_o  out  WIDTH  head payload.
- count_o  out  CW  current number of held entries.

Behaviour:
- Storage: circular buffer of DEPTH entries with wr_ptr and rd_ptr (log2(DEPTH) bits, natural wrap) and a count register.
- Reset (rst_i=0, async): count=0, pointers=0, out_valid_o=0, in_ready_o=1, out_data_o=0, count_o=0. Storage contents need not be reset.
- push = in_valid_i & in_ready_o & ~flush_i.
- pop = out_valid_o & out_ready_i & ~flush_i.
- in_ready_o = (count != DEPTH). It is decoded from registers only; there is no combinational path from out_ready_i or in_valid_i.
- out_valid_o = (count != 0). It is registered-derived.
- out_data_o = mem[rd_ptr] when out_valid_o=1, else all-zero. This gives a deterministic bubble, equivalent to a NOP.
- Latency: a payload pushed into an empty stage appears on out_data_o with out_valid_o=1 on the next cycle. There is no same-cycle bypass.
- Throughput: with DEPTH≥2, one push and one pop per cycle are sustained indefinitely.
- Count update, per cycle:
  - push only: count+1.
  - pop only: count−1.
  - push and pop together: count unchanged, both pointers advance.
  - neither: unchanged.
- Full (count=DEPTH): in_ready_o=0 and in_data_i is ignored.
  - A pop in the same cycle does not make the stage accept input that cycle; in_ready_o rises the following cycle.
- Empty (count=0): out_valid_o=0 and out_ready_i is ignored. count never underflows.
- Stability: while out_valid_o=1 and out_ready_i=0, out_data_o and out_valid_o hold constant. Upstream must likewise hold in_data_i while in_valid_i=1 and in_ready_o=0 (protocol rule; the bench checks it with an assertion).
- flush_i=1 at a clock edge:
  - count and both pointers go to 0, so out_valid_o=0 and in_ready_o=1 next cycle.
  - Any simultaneous push is dropped; the simultaneous pop is not counted.
  - Flush has priority over every other event.
- Flush held multiple cycles: stage stays empty throughout.
- Reset asserted mid-transfer: state returns to reset values immediately (asynchronously). Held payloads are lost. No output glitch other than the transition to reset values.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. FIFO order is preserved across the wrap.

Test Plan:
1. Reset/idle: release rst_i, hold all inputs 0 → out_valid_o=0, in_ready_o=1, count_o=0, out_data_o=0x00000000.
2. Single transfer:
   - push 0xDEADBEEF with out_ready_i=1 → next cycle out_valid_o=1, out_data_o=0xDEADBEEF.
   - the following cycle → out_valid_o=0, count_o=0.
3. Backpressure/full (DEPTH=2):
   - out_ready_i=0, push 0x11 then 0x22 → count_o=2, in_ready_o=0.
   - offer 0x33 → not accepted.
   - raise out_ready_i → outputs 0x11 then 0x22 in order; in_ready_o=1 one cycle after the first pop.
4. Streaming: in_valid_i=out_ready_i=1 for 10 cycles with data 1..10 → out_data_o shows 1..10 on consecutive cycles after 1-cycle latency; count_o stays 1; the pointers wrap with no loss.
5. Flush with concurrent push:
   - with 0xAA and 0xBB held, assert flush_i for 1 cycle while pushing 0xCC → next cycle count_o=0, out_valid_o=0.
   - 0xCC is never output.
   - a subsequent push of 0xDD appears alone.
6. Async reset mid-operation: with count_o=2, pulse rst_i low between clock edges → outputs go to reset values before the next edge; after release, pushing 0x5A yields exactly 0x5A.
